// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: state encoding,
// opcode values, ALU-op codes, datapath mux selects and the control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Everything the FSM drives into the datapath, decoded per state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       retire;
    logic [1:0] alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory-stall watchdog: counts consecutive cycles a request waits without
// mem_ready and flags a timeout on the stall cycle that reaches the limit.
module mc_mem_watchdog #(
  parameter int MEM_WAIT_MAX = 0,
  parameter int WD_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [WD_W-1:0] CNT_SAT = '1;

  logic [WD_W-1:0] r_cnt;
  logic            w_stall;

  assign w_stall = i_req & ~i_ready;

  // Stall counter: clears on completion or when no request is pending, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_stall) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A completing cycle is never a stall, so completion beats the threshold.
  generate
    if (MEM_WAIT_MAX == 0) begin : g_wd_off
      assign o_timeout = 1'b0;
    end else begin : g_wd_on
      localparam logic [WD_W-1:0] CNT_LAST = WD_W'(MEM_WAIT_MAX - 1);
      assign o_timeout = w_stall & (r_cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback
// sequencing, Moore-style control decode, sticky illegal and bus traps.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0,
  parameter int WD_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err
);

  state_t r_state;
  state_t w_state_next;
  ctrl_t  w_ctrl;
  logic   w_mem_req;
  logic   w_timeout;
  logic   r_illegal;
  logic   r_bus_err;

  mc_mem_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .WD_W        (WD_W)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_mem_req),
    .i_ready  (mem_ready),
    .o_timeout(w_timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_R:              w_state_next = S_EXEC_R;
          OP_I:              w_state_next = S_EXEC_I;
          OP_BR:             w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          OP_LUI:            w_state_next = S_LUI;
          OP_AUIPC:          w_state_next = S_ALUWB;
          OP_FENCE:          w_state_next = S_FETCH;
          default:           w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_state_next = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      w_state_next = S_MEMWB;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_MEMWR: begin
        if (mem_ready)      w_state_next = S_FETCH;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_MEMWB:  w_state_next = S_FETCH;
      S_EXEC_R: w_state_next = S_ALUWB;
      S_EXEC_I: w_state_next = S_ALUWB;
      S_LUI:    w_state_next = S_ALUWB;
      S_ALUWB:  w_state_next = S_FETCH;
      S_JALR:   w_state_next = S_JAL;
      S_JAL:    w_state_next = S_ALUWB;
      S_BRANCH: w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Sticky trap causes, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_DECODE && w_state_next == S_TRAP) r_illegal <= 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  // Output decode per state; unlisted fields stay zero.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.alusrc_a   = SRCA_PC;
        w_ctrl.alusrc_b   = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.ir_we      = mem_ready;
        w_ctrl.pc_we      = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alusrc_a = SRCA_OLDPC;
        w_ctrl.alusrc_b = SRCB_IMM;
        w_ctrl.alu_op   = ALUOP_ADD;
        w_ctrl.retire   = (opcode == OP_FENCE);
      end
      S_MEMADR, S_JALR: begin
        w_ctrl.alusrc_a = SRCA_RS1;
        w_ctrl.alusrc_b = SRCB_IMM;
        w_ctrl.alu_op   = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_we     = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_we  = 1'b1;
        w_ctrl.adr_src = 1'b1;
        w_ctrl.retire  = mem_ready;
      end
      S_EXEC_R: begin
        w_ctrl.alusrc_a = SRCA_RS1;
        w_ctrl.alusrc_b = SRCB_RS2;
        w_ctrl.alu_op   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        w_ctrl.alusrc_a = SRCA_RS1;
        w_ctrl.alusrc_b = SRCB_IMM;
        w_ctrl.alu_op   = ALUOP_FUNCT;
      end
      S_LUI: begin
        w_ctrl.alusrc_a = SRCA_ZERO;
        w_ctrl.alusrc_b = SRCB_IMM;
        w_ctrl.alu_op   = ALUOP_ADD;
      end
      S_ALUWB: begin
        w_ctrl.reg_we     = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.retire     = 1'b1;
      end
      S_JAL: begin
        w_ctrl.pc_we      = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.alusrc_a   = SRCA_OLDPC;
        w_ctrl.alusrc_b   = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
      end
      S_BRANCH: begin
        w_ctrl.alusrc_a   = SRCA_RS1;
        w_ctrl.alusrc_b   = SRCB_RS2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_we      = br_cond;
        w_ctrl.retire     = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Strobes are masked combinationally so they drop the moment reset asserts.
  assign w_mem_req  = w_ctrl.mem_req & rst_n;
  assign mem_req    = w_mem_req;
  assign mem_we     = w_ctrl.mem_we & rst_n;
  assign ir_we      = w_ctrl.ir_we & rst_n;
  assign pc_we      = w_ctrl.pc_we & rst_n;
  assign reg_we     = w_ctrl.reg_we & rst_n;
  assign retire     = w_ctrl.retire & rst_n;
  assign adr_src    = w_ctrl.adr_src;
  assign alusrc_a   = w_ctrl.alusrc_a;
  assign alusrc_b   = w_ctrl.alusrc_b;
  assign result_src = w_ctrl.result_src;
  assign alu_op     = w_ctrl.alu_op;
  assign illegal    = r_illegal;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: an instruction-level model builds the
// expected per-cycle control outputs; a negedge process compares them.
module tb_mc_ctrl_fsm;

  localparam int WAIT_MAX = 4;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_FENCE = 7'b0001111;
  localparam logic [6:0] T_SYS   = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       br_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire, illegal, bus_err;
  logic [1:0] alusrc_a, alusrc_b, result_src, alu_op;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(WAIT_MAX), .WD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_cond(br_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .result_src(result_src),
    .alu_op(alu_op), .retire(retire), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire;
    logic [1:0] a, b, res, aop;
    logic       illegal, bus_err;
  } exp_t;

  int    total = 0;
  int    bad = 0;
  exp_t  exp_o;
  exp_t  act;
  string exp_tag = "";
  bit    exp_valid = 1'b0;
  bit    m_illegal = 1'b0;
  bit    m_bus_err = 1'b0;

  assign act = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire,
                alusrc_a, alusrc_b, result_src, alu_op, illegal, bus_err};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, a, e);
    end
  endtask

  // Per-cycle comparison of every output against the model's expectation.
  always @(negedge clk) begin
    if (exp_valid) chk(exp_tag, 32'(act), 32'(exp_o));
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic exp_t mk(input logic mr, we, adr, ir, pc, rw, ret,
                              input logic [1:0] a, b, res, aop);
    exp_t e;
    e.mem_req = mr; e.mem_we = we; e.adr_src = adr; e.ir_we = ir;
    e.pc_we = pc; e.reg_we = rw; e.retire = ret;
    e.a = a; e.b = b; e.res = res; e.aop = aop;
    e.illegal = m_illegal; e.bus_err = m_bus_err;
    return e;
  endfunction

  task automatic cyc(input exp_t e, input string tag, inout int n);
    exp_o = e; exp_tag = tag; exp_valid = 1'b1; n++;
    @(posedge clk); #1;
  endtask

  task automatic step(input logic br, input logic [1:0] a, b, res, aop,
                      input logic pc, rw, ret, input string tag, inout int n);
    mem_ready = rb(); br_cond = br;
    cyc(mk(0, 0, 0, 0, pc, rw, ret, a, b, res, aop), tag, n);
  endtask

  // One memory transaction: `stalls` waiting cycles then completion, unless
  // the watchdog limit is reached first.
  task automatic mem_phase(input logic [6:0] op, input logic isf, adr, we,
                           input int stalls, input string tag, inout int n,
                           output bit trapped);
    logic [1:0] b, res, aop;
    trapped = 1'b0;
    b = isf ? 2'b10 : 2'b00; res = isf ? 2'b10 : 2'b00; aop = isf ? 2'b01 : 2'b00;
    for (int k = 0; k < stalls; k++) begin
      opcode = isf ? 7'($urandom) : op; mem_ready = 1'b0; br_cond = rb();
      cyc(mk(1, we, adr, 0, 0, 0, 0, 2'b00, b, res, aop), tag, n);
      if (k == WAIT_MAX - 1) begin
        trapped = 1'b1; m_bus_err = 1'b1;
        return;
      end
    end
    opcode = isf ? 7'($urandom) : op; mem_ready = 1'b1; br_cond = rb();
    cyc(mk(1, we, adr, isf, isf, 0, we, 2'b00, b, res, aop), tag, n);
  endtask

  task automatic decode_step(input logic [6:0] op, inout int n);
    opcode = op; mem_ready = rb(); br_cond = rb();
    cyc(mk(0, 0, 0, 0, 0, 0, op == T_FENCE, 2'b01, 2'b01, 2'b00, 2'b01), "decode", n);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic br, input int fst, mst,
                           output int n, output bit trapped);
    n = 0;
    mem_phase(op, 1, 0, 0, fst, "fetch", n, trapped);
    if (trapped) return;
    decode_step(op, n);
    case (op)
      T_LOAD, T_STORE: begin
        step(rb(), 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, "memadr", n);
        mem_phase(op, 0, 1, op[5], mst, "mem", n, trapped);
        if (!trapped && !op[5]) step(rb(), 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 1, "memwb", n);
      end
      T_R:     step(rb(), 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, "exec_r", n);
      T_I:     step(rb(), 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, "exec_i", n);
      T_LUI:   step(rb(), 2'b11, 2'b01, 2'b00, 2'b01, 0, 0, 0, "lui", n);
      T_JALR:  step(rb(), 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, "jalr", n);
      T_BR:    step(br,   2'b10, 2'b00, 2'b00, 2'b10, br, 0, 1, "branch", n);
      T_AUIPC, T_JAL, T_FENCE: ;
      default: begin m_illegal = 1'b1; trapped = 1'b1; end
    endcase
    if (op == T_JALR || op == T_JAL)
      step(rb(), 2'b01, 2'b10, 2'b00, 2'b01, 1, 0, 0, "jal", n);
    if (op == T_R || op == T_I || op == T_LUI || op == T_AUIPC || op == T_JALR || op == T_JAL)
      step(rb(), 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, "aluwb", n);
  endtask

  task automatic trap_idle(input int cycles);
    int d = 0;
    for (int i = 0; i < cycles; i++) begin
      opcode = 7'($urandom); mem_ready = rb(); br_cond = rb();
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), "trap", d);
    end
  endtask

  task automatic do_reset();
    int d = 0;
    rst_n = 1'b0; m_illegal = 1'b0; m_bus_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = rb(); opcode = 7'($urandom);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b01), "reset", d);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit t;
    logic [6:0] ops [12];
    logic [6:0] op;
    ops = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI,
            T_AUIPC, T_FENCE, T_SYS, 7'b0000000};

    @(posedge clk); #1;
    do_reset();

    run_instr(T_R, 0, 0, 0, n, t);      chk("lat_r", n, 4);  chk("trap_r", 32'(t), 0);
    run_instr(T_LOAD, 0, 0, 3, n, t);   chk("lat_load_st3", n, 8);
    run_instr(T_BR, 1, 0, 0, n, t);     chk("lat_br_taken", n, 3);
    run_instr(T_BR, 0, 0, 0, n, t);     chk("lat_br_not", n, 3);
    run_instr(T_JALR, 0, 0, 0, n, t);   chk("lat_jalr", n, 5);
    run_instr(T_STORE, 0, 0, 0, n, t);  chk("lat_store", n, 4);
    run_instr(T_FENCE, 0, 0, 0, n, t);  chk("lat_fence", n, 2);

    run_instr(T_SYS, 0, 0, 0, n, t);    chk("illegal_trap", 32'(t), 1);
    trap_idle(20);
    do_reset();

    run_instr(T_R, 0, 4, 0, n, t);      chk("wd_trap_fetch", 32'(t), 1);
    trap_idle(5);
    do_reset();
    run_instr(T_R, 0, 3, 0, n, t);      chk("wd_edge_no_trap", 32'(t), 0); chk("lat_r_st3", n, 7);
    run_instr(T_STORE, 0, 0, 4, n, t);  chk("wd_trap_store", 32'(t), 1);
    trap_idle(4);
    do_reset();

    // Reset in the middle of a stalled load read must drop mem_req at once.
    n = 0;
    mem_phase(T_LOAD, 1, 0, 0, 0, "fetch", n, t);
    decode_step(T_LOAD, n);
    step(rb(), 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, "memadr", n);
    mem_ready = 1'b0;
    cyc(mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), "memrd", n);
    exp_valid = 1'b0;
    #2;
    chk("req_before_rst", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("req_async_drop", 32'(mem_req), 0);
    chk("adr_after_rst", 32'(adr_src), 0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 250; i++) begin
      int fst, mst;
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      fst = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 5);
      mst = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 5);
      run_instr(op, rb(), fst, mst, n, t);
      if (t) begin
        trap_idle($urandom_range(1, 4));
        do_reset();
      end
    end

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
